// File: rtl/mcu_route_pkg.sv
// Shared mode encodings and index helpers for the MCU memory/convolver router.
package mcu_route_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'd0,
    MODE_PROC = 2'd1,
    MODE_OUT  = 2'd2,
    MODE_IDLE = 2'd3
  } mode_e;

  // (a+b) mod nmem; both operands are always below nmem, so one conditional subtract suffices
  function automatic int wrap_add(input int a, input int b, input int nmem);
    int sum;
    sum = a + b;
    return (sum >= nmem) ? sum - nmem : sum;
  endfunction

endpackage

// File: rtl/mcu_window_rot.sv
// Rotates the NMEM memory lanes by the base offset and cuts out N overlapping three-row windows.
module mcu_window_rot
  import mcu_route_pkg::*;
#(
  parameter  int N    = 2,
  parameter  int B    = 11,
  localparam int NMEM = N + 2,
  localparam int IW   = $clog2(NMEM)
) (
  input  logic [IW-1:0]             base,
  input  logic [NMEM-1:0][B-1:0]    lanes,
  output logic [N-1:0][2:0][B-1:0]  win
);

  for (genvar k = 0; k < N; k++) begin : g_conv
    for (genvar j = 0; j < 3; j++) begin : g_tap
      logic [IW-1:0] idx;
      assign idx        = IW'(wrap_add(k + j, int'(base), NMEM));
      assign win[k][j]  = lanes[idx];
    end
  end

endmodule

// File: rtl/mcu_route_seq.sv
// Registered router between the N+2 row memories and N convolvers: load, rotating-window passes, readout.
// Define MCU_ROUTE_OUTREG_EN to add a second register stage on the window and readout outputs.
module mcu_route_seq
  import mcu_route_pkg::*;
#(
  parameter  int N           = 2,
  parameter  int BITS_IMAGEN = 11,
  parameter  int BITS_DATA   = BITS_IMAGEN,
  localparam int NMEM        = N + 2,
  localparam int NSUB        = N / 2 + 1,
  localparam int SW          = $clog2(NSUB)
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [1:0]                     i_mode,
  input  logic [BITS_DATA-1:0]           i_Data,
  input  logic                           i_dataValid,
  input  logic                           i_readReq,
  input  logic [NMEM*BITS_IMAGEN-1:0]    i_MemData,
  input  logic                           i_memValid,
  input  logic [N*BITS_IMAGEN-1:0]       i_DataConv,
  input  logic                           i_convValid,
  input  logic                           i_passDone,
  output logic [3*N*BITS_IMAGEN-1:0]     o_DataConv,
  output logic                           o_winValid,
  output logic [NMEM*BITS_IMAGEN-1:0]    o_MemData,
  output logic [NMEM-1:0]                o_MemWe,
  output logic [BITS_DATA-1:0]           o_Data,
  output logic                           o_outValid,
  output logic [SW-1:0]                  o_substate
);

  localparam int B  = BITS_IMAGEN;
  localparam int IW = $clog2(NMEM);
`ifdef MCU_ROUTE_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  mode_e                     mode, prev_mode;
  logic                      load_entry, out_entry;
  logic                      do_load, do_wb, do_win, do_rd, do_pass;
  logic [IW-1:0]             lp, rp, lp_cur, rp_cur, base;
  logic [SW-1:0]             s, s_cur, s_nxt;
  logic [NMEM-1:0][B-1:0]    mem_lanes, md_d;
  logic [N-1:0][B-1:0]       conv_lanes;
  logic [NMEM-1:0]           we_d;
  logic [N-1:0][2:0][B-1:0]  win;
  logic [3*N*B-1:0]          win_d;
  logic [BITS_DATA-1:0]      rd_d;

  logic [STAGES:1]                 win_vld_pipe, rd_vld_pipe;
  logic [STAGES:1][3*N*B-1:0]      win_pipe;
  logic [STAGES:1][BITS_DATA-1:0]  rd_pipe;

  assign mode       = mode_e'(i_mode);
  assign mem_lanes  = i_MemData;
  assign conv_lanes = i_DataConv;

  // Mode entry resets the pointers in the same cycle, so the first item lands on lane 0
  assign load_entry = (mode == MODE_LOAD) && (prev_mode != MODE_LOAD);
  assign out_entry  = (mode == MODE_OUT)  && (prev_mode != MODE_OUT);
  assign lp_cur     = load_entry ? '0 : lp;
  assign rp_cur     = out_entry  ? '0 : rp;
  assign s_cur      = load_entry ? '0 : s;
  assign s_nxt      = (s == SW'(NSUB - 1)) ? '0 : s + SW'(1);

  assign do_load = (mode == MODE_LOAD) && i_dataValid;
  assign do_wb   = (mode == MODE_PROC) && i_convValid;
  assign do_win  = (mode == MODE_PROC) && i_memValid;
  assign do_pass = (mode == MODE_PROC) && i_passDone;
  assign do_rd   = (mode == MODE_OUT)  && i_readReq;

  // Base offset (N*s) mod NMEM as a constant table indexed by s
  always_comb begin
    base = '0;
    for (int i = 0; i < NSUB; i++)
      if (s == SW'(i)) base = IW'((N * i) % NMEM);
  end

  mcu_window_rot #(.N(N), .B(B)) u_rot (
    .base  (base),
    .lanes (mem_lanes),
    .win   (win)
  );

  always_comb begin
    we_d = '0;
    md_d = '0;
    if (do_load) begin
      we_d[lp_cur] = 1'b1;
      md_d[lp_cur] = i_Data;
    end else if (do_wb) begin
      for (int k = 0; k < N; k++) begin
        we_d[IW'(wrap_add(int'(base), k, NMEM))] = 1'b1;
        md_d[IW'(wrap_add(int'(base), k, NMEM))] = conv_lanes[k];
      end
    end
  end

  assign win_d = do_win ? win : '0;
  assign rd_d  = do_rd ? mem_lanes[rp_cur] : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prev_mode <= MODE_IDLE;
      lp        <= '0;
      rp        <= '0;
      s         <= '0;
      o_MemWe   <= '0;
      o_MemData <= '0;
    end else begin
      prev_mode <= mode;
      lp        <= do_load ? IW'(wrap_add(int'(lp_cur), 1, NMEM)) : lp_cur;
      rp        <= do_rd   ? IW'(wrap_add(int'(rp_cur), 1, NMEM)) : rp_cur;
      s         <= do_pass ? s_nxt : s_cur;
      o_MemWe   <= we_d;
      o_MemData <= md_d;
    end
  end

  // Window/readout path: stage 1 always, stage 2 only with the extra output register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      win_vld_pipe <= '0;
      win_pipe     <= '0;
      rd_vld_pipe  <= '0;
      rd_pipe      <= '0;
    end else begin
      win_vld_pipe[1] <= do_win;
      win_pipe[1]     <= win_d;
      rd_vld_pipe[1]  <= do_rd;
      rd_pipe[1]      <= rd_d;
      for (int i = 2; i <= STAGES; i++) begin
        win_vld_pipe[i] <= win_vld_pipe[i-1];
        win_pipe[i]     <= win_pipe[i-1];
        rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
        rd_pipe[i]      <= rd_pipe[i-1];
      end
    end
  end

  assign o_winValid = win_vld_pipe[STAGES];
  assign o_DataConv = win_pipe[STAGES];
  assign o_outValid = rd_vld_pipe[STAGES];
  assign o_Data     = rd_pipe[STAGES];
  assign o_substate = s;

endmodule
